cmd_encod_linear_rw: RTL

Parametrised command-sequence encoder for single-page linear DDR3 transfers in either direction. It generates ACTIVATE, then N READ or WRITE bursts at consecutive columns, then PRECHARGE, with programmable inter-command pauses. Its output is a stream of 32-bit encoded sequencer words (enc_cmd/enc_wr/enc_done) for the memory controller command sequencer. It is a single drop-in encoder that serves both read and write channels.

---
 rtl/cmd_encod_linear_rw_pkg.sv | 59 +++++
 rtl/cmd_encod_linear_rw.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/cmd_encod_linear_rw_pkg.sv
// Shared command-word definitions for the sequencer encoders: RAS/CAS/WE
// codes and the functions that pack a command or pause into a 32-bit word.
package cmd_encod_linear_rw_pkg;

    localparam logic [2:0] RCW_NOP       = 3'd0;
    localparam logic [2:0] RCW_READ      = 3'd2;
    localparam logic [2:0] RCW_WRITE     = 3'd3;
    localparam logic [2:0] RCW_ACTIVATE  = 3'd4;
    localparam logic [2:0] RCW_PRECHARGE = 3'd5;

    // Pause words reuse the address field: skip count in the low bits,
    // the sequence-done flag just above it.
    localparam int SKIP_W       = 10;
    localparam int CMD_DONE_BIT = 10;

    // Word layout, MSB first:
    // addr[14:0] bank[2:0] rcw[2:0] odt_en cke sel dq_en dqs_en dqs_toggle
    // dci buf_wr buf_rd nop buf_rst
    function automatic logic [31:0] func_encode_cmd(
        input logic [14:0] addr,
        input logic [2:0]  bank,
        input logic [2:0]  rcw,
        input logic        odt_en,
        input logic        cke,
        input logic        sel,
        input logic        dq_en,
        input logic        dqs_en,
        input logic        dqs_toggle,
        input logic        dci,
        input logic        buf_wr,
        input logic        buf_rd,
        input logic        nop,
        input logic        buf_rst
    );
        return {addr, bank, rcw, odt_en, cke, sel, dq_en, dqs_en, dqs_toggle,
                dci, buf_wr, buf_rd, nop, buf_rst};
    endfunction

    function automatic logic [31:0] func_encode_skip(
        input logic [SKIP_W-1:0] skip,
        input logic              done,
        input logic [2:0]        bank,
        input logic              odt_en,
        input logic              cke,
        input logic              sel,
        input logic              dq_en,
        input logic              dqs_en,
        input logic              dqs_toggle,
        input logic              dci,
        input logic              buf_wr,
        input logic              buf_rd,
        input logic              buf_rst
    );
        return func_encode_cmd({{(14 - CMD_DONE_BIT){1'b0}}, done, skip},
                               bank, RCW_NOP, odt_en, cke, sel, dq_en, dqs_en,
                               dqs_toggle, dci, buf_wr, buf_rd, 1'b0, buf_rst);
    endfunction

endpackage

// File: rtl/cmd_encod_linear_rw.sv
// Linear single-page read/write command encoder: ACTIVATE, N column bursts,
// PRECHARGE, with fixed pauses, emitted as one sequencer word per cycle.
//
// state      | meaning
// -----------+-----------------------------------------------
// S_IDLE     | waiting for start, no word emitted
// S_ACT      | ACTIVATE word (row, bank)
// S_ACT_WAIT | pause for tRCD
// S_XFER     | one READ/WRITE word per cycle, N cycles
// S_TAIL     | read turnaround / write recovery pause
// S_PGNEXT   | pause carrying the buffer page-advance flag
// S_PRE      | PRECHARGE word (bank)
// S_PRE_WAIT | pause for tRP
// S_FIN      | pause word with done set
module cmd_encod_linear_rw
    import cmd_encod_linear_rw_pkg::*;
#(
    parameter int   ADDRESS_NUMBER = 15,
    parameter int   COLADDR_NUMBER = 10,
    parameter int   NUM_XFER_BITS  = 6,
    parameter int   CMD_PAUSE_BITS = 10,
    parameter logic RSEL           = 1'b1,
    parameter logic WSEL           = 1'b0,
    parameter int   T_RCD_SKIP     = 1,
    parameter int   T_RP_SKIP      = 2,
    parameter int   WR_RECOV_SKIP  = 3
) (
    input  logic                        clk,
    input  logic                        mrst_n,
    input  logic [2:0]                  bank_in,
    input  logic [ADDRESS_NUMBER-1:0]   row_in,
    input  logic [COLADDR_NUMBER-4:0]   start_col,
    input  logic [NUM_XFER_BITS-1:0]    num128_in,
    input  logic                        wr_mode_in,
    input  logic                        skip_next_page_in,
    input  logic                        start,
    output logic                        busy,
    output logic [31:0]                 enc_cmd,
    output logic                        enc_wr,
    output logic                        enc_done
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ACT,
        S_ACT_WAIT,
        S_XFER,
        S_TAIL,
        S_PGNEXT,
        S_PRE,
        S_PRE_WAIT,
        S_FIN
    } state_t;

    localparam logic [CMD_PAUSE_BITS-1:0] SKIP_RCD   = CMD_PAUSE_BITS'(T_RCD_SKIP);
    localparam logic [CMD_PAUSE_BITS-1:0] SKIP_RP    = CMD_PAUSE_BITS'(T_RP_SKIP);
    localparam logic [CMD_PAUSE_BITS-1:0] SKIP_RECOV = CMD_PAUSE_BITS'(WR_RECOV_SKIP);
    localparam logic [CMD_PAUSE_BITS-1:0] SKIP_RD    = CMD_PAUSE_BITS'(1);
    localparam logic [CMD_PAUSE_BITS-1:0] SKIP_NONE  = '0;

    state_t                      state, state_nxt;
    logic [2:0]                  bank_q;
    logic [ADDRESS_NUMBER-1:0]   row_q;
    logic [COLADDR_NUMBER-4:0]   col_q;
    logic [NUM_XFER_BITS:0]      cnt_q;
    logic                        wr_q;
    logic                        skp_q;
    logic                        done_q;
    logic                        accept;
    logic                        sel_x;
    logic [CMD_PAUSE_BITS-1:0]   skip_tail;

    // busy also covers the enc_done cycle, so a start there is dropped
    assign busy   = (state != S_IDLE) || done_q;
    assign accept = start && !busy;

    // State register
    always_ff @(posedge clk or negedge mrst_n) begin
        if (!mrst_n) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic; XFER leaves when the burst counter reaches its last word
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (accept) state_nxt = S_ACT;
            S_ACT:      state_nxt = S_ACT_WAIT;
            S_ACT_WAIT: state_nxt = S_XFER;
            S_XFER:     if (cnt_q == (NUM_XFER_BITS+1)'(1)) state_nxt = S_TAIL;
            S_TAIL:     state_nxt = S_PGNEXT;
            S_PGNEXT:   state_nxt = S_PRE;
            S_PRE:      state_nxt = S_PRE_WAIT;
            S_PRE_WAIT: state_nxt = S_FIN;
            S_FIN:      state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Request fields are captured only on an accepted start
    always_ff @(posedge clk or negedge mrst_n) begin
        if (!mrst_n) begin
            bank_q <= '0;
            row_q  <= '0;
            wr_q   <= 1'b0;
            skp_q  <= 1'b0;
        end else if (accept) begin
            bank_q <= bank_in;
            row_q  <= row_in;
            wr_q   <= wr_mode_in;
            skp_q  <= skip_next_page_in;
        end
    end

    // Burst down-counter (one extra bit so a zero request means the full count)
    // and column counter, which wraps naturally at its width
    always_ff @(posedge clk or negedge mrst_n) begin
        if (!mrst_n) begin
            cnt_q <= '0;
            col_q <= '0;
        end else if (accept) begin
            cnt_q <= (num128_in == '0) ? {1'b1, {NUM_XFER_BITS{1'b0}}}
                                       : {1'b0, num128_in};
            col_q <= start_col;
        end else if (state == S_XFER) begin
            cnt_q <= cnt_q - 1'b1;
            col_q <= col_q + 1'b1;
        end
    end

    // enc_done trails the FIN word by one cycle
    always_ff @(posedge clk or negedge mrst_n) begin
        if (!mrst_n) done_q <= 1'b0;
        else         done_q <= (state == S_FIN);
    end

    assign sel_x     = wr_q ? WSEL : RSEL;
    assign skip_tail = wr_q ? SKIP_RECOV : SKIP_RD;
    assign enc_done  = done_q;

    // Word decode from the current state and the captured request
    always_comb begin
        enc_cmd = '0;
        enc_wr  = (state != S_IDLE);
        case (state)
            S_ACT:
                enc_cmd = func_encode_cmd(15'(row_q), bank_q, RCW_ACTIVATE,
                              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                              1'b0, 1'b0, 1'b0, 1'b0);
            S_ACT_WAIT:
                enc_cmd = func_encode_skip(SKIP_RCD, 1'b0, 3'b000,
                              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                              1'b0, 1'b0, 1'b0);
            S_XFER:
                enc_cmd = func_encode_cmd(15'({col_q, 3'b000}), bank_q,
                              wr_q ? RCW_WRITE : RCW_READ,
                              wr_q, 1'b0, sel_x, wr_q, wr_q, wr_q, !wr_q,
                              !wr_q, wr_q, 1'b1, 1'b0);
            S_TAIL:
                enc_cmd = func_encode_skip(skip_tail, 1'b0, 3'b000,
                              wr_q, 1'b0, sel_x, wr_q, wr_q, 1'b0, !wr_q,
                              1'b0, 1'b0, 1'b0);
            S_PGNEXT:
                enc_cmd = func_encode_skip(SKIP_NONE, 1'b0, 3'b000,
                              1'b0, 1'b0, wr_q ? 1'b0 : RSEL, 1'b0, 1'b0, 1'b0,
                              !wr_q, 1'b0, 1'b0, !skp_q);
            S_PRE:
                enc_cmd = func_encode_cmd(15'd0, bank_q, RCW_PRECHARGE,
                              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, !wr_q,
                              1'b0, 1'b0, 1'b0, 1'b0);
            S_PRE_WAIT:
                enc_cmd = func_encode_skip(SKIP_RP, 1'b0, 3'b000,
                              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, !wr_q,
                              1'b0, 1'b0, 1'b0);
            S_FIN:
                enc_cmd = func_encode_skip(SKIP_NONE, 1'b1, 3'b000,
                              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                              1'b0, 1'b0, 1'b0);
            default:
                enc_cmd = '0;
        endcase
    end

endmodule
